// File: rtl/pulse_conditioner_if.sv
// Signal bundle between the raw pad pulse source and the pulse conditioner.
// The slave side is the conditioner; the master side drives raw_pulse and observes results.
interface pulse_conditioner_if;
   logic       raw_pulse;
   logic       clean_pulse;
   logic       clk_by_5;
   logic [7:0] pulse_width;
   logic       width_valid;
   logic       width_sat;
   logic       glitch;

   modport master (
      output raw_pulse,
      input  clean_pulse,
      input  clk_by_5,
      input  pulse_width,
      input  width_valid,
      input  width_sat,
      input  glitch
   );

   modport slave (
      input  raw_pulse,
      output clean_pulse,
      output clk_by_5,
      output pulse_width,
      output width_valid,
      output width_sat,
      output glitch
   );
endinterface

// File: rtl/pulse_conditioner.sv
// Synchronises a raw pad pulse, rejects short glitches, enforces a low gap between pulses,
// measures qualified pulse width and generates a free-running divide-by-5 clock.
module pulse_conditioner #(
   parameter int unsigned MIN_WIDTH  = 3,
   parameter int unsigned MAX_WIDTH  = 255,
   parameter int unsigned GAP_CYCLES = 4
) (
   input logic           clk,
   input logic           rst,
   pulse_conditioner_if.slave pc
);

   localparam logic [7:0] MinW = 8'(MIN_WIDTH);
   localparam logic [7:0] MaxW = 8'(MAX_WIDTH);
   localparam logic [3:0] GapN = 4'(GAP_CYCLES);

   typedef enum logic [1:0] {StIdle, StQualify, StActive, StGap} state_e;

   state_e     state_q, state_d;
   logic       sync1_q, s_in;
   logic [7:0] width_cnt_q, width_cnt_d;
   logic [3:0] gap_cnt_q, gap_cnt_d;
   logic [2:0] div_q, div_d;
   logic       clk5_q, clk5_d;
   logic       clean_q, clean_d;
   logic [7:0] pw_q, pw_d;
   logic       valid_q, valid_d;
   logic       sat_q, sat_d;
   logic       glitch_q, glitch_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         s_in        <= 1'b0;
         state_q     <= StIdle;
         width_cnt_q <= '0;
         gap_cnt_q   <= '0;
         div_q       <= '0;
         clk5_q      <= 1'b0;
         clean_q     <= 1'b0;
         pw_q        <= '0;
         valid_q     <= 1'b0;
         sat_q       <= 1'b0;
         glitch_q    <= 1'b0;
      end else begin
         sync1_q     <= pc.raw_pulse;
         s_in        <= sync1_q;
         state_q     <= state_d;
         width_cnt_q <= width_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         div_q       <= div_d;
         clk5_q      <= clk5_d;
         clean_q     <= clean_d;
         pw_q        <= pw_d;
         valid_q     <= valid_d;
         sat_q       <= sat_d;
         glitch_q    <= glitch_d;
      end
   end

   // Divider phase 1 and 2 map to the high portion so the output is high right after reset.
   always_comb begin
      div_d  = (div_q == 3'd4) ? 3'd0 : div_q + 3'd1;
      clk5_d = (div_d == 3'd1) || (div_d == 3'd2);
   end

   always_comb begin
      state_d     = state_q;
      width_cnt_d = width_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      clean_d     = clean_q;
      pw_d        = pw_q;
      sat_d       = sat_q;
      valid_d     = 1'b0;
      glitch_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            clean_d = 1'b0;
            if (s_in) begin
               width_cnt_d = 8'd1;
               if (MinW == 8'd1) begin
                  state_d = StActive;
                  clean_d = 1'b1;
               end else begin
                  state_d = StQualify;
               end
            end
         end
         StQualify: begin
            if (s_in) begin
               width_cnt_d = width_cnt_q + 8'd1;
               if (width_cnt_d == MinW) begin
                  state_d = StActive;
                  clean_d = 1'b1;
               end
            end else begin
               glitch_d = 1'b1;
               state_d  = StIdle;
            end
         end
         StActive: begin
            if (!s_in || (width_cnt_q == MaxW)) begin
               clean_d   = 1'b0;
               pw_d      = width_cnt_q;
               sat_d     = s_in;
               valid_d   = 1'b1;
               gap_cnt_d = '0;
               state_d   = StGap;
            end else begin
               width_cnt_d = width_cnt_q + 8'd1;
               clean_d     = 1'b1;
            end
         end
         StGap: begin
            clean_d = 1'b0;
            if (s_in) begin
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
               if (gap_cnt_d == GapN) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign pc.clean_pulse = clean_q;
   assign pc.clk_by_5    = clk5_q;
   assign pc.pulse_width = pw_q;
   assign pc.width_valid = valid_q;
   assign pc.width_sat   = sat_q;
   assign pc.glitch      = glitch_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Bench for pulse_conditioner: directed scenarios plus random pulse trains, checked every cycle
// against a run-length reference model.
module tb_pulse_conditioner;

   localparam int MinW = 3;
   localparam int MaxW = 255;
   localparam int GapN = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;
   int   clean_seen;

   pulse_conditioner_if bus ();

   pulse_conditioner #(
      .MIN_WIDTH  (MinW),
      .MAX_WIDTH  (MaxW),
      .GAP_CYCLES (GapN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .pc  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw samples reach the decision logic two edges late; a pulse is a run of
   // highs seen while "ready" (gap satisfied), reported when it ends or exceeds MaxW.
   int   run_len;
   int   low_len;
   bit   ready;
   bit   d1, d2;
   int   since_rst;
   logic exp_clean, exp_valid, exp_sat, exp_glitch, exp_clk5;
   logic [7:0] exp_pw;

   task automatic model_step(input logic raw_v, input logic rst_v);
      bit s;
      exp_valid  = 1'b0;
      exp_glitch = 1'b0;
      if (rst_v) begin
         run_len = 0; low_len = 0; ready = 1'b1; d1 = 1'b0; d2 = 1'b0; since_rst = 0;
         exp_clean = 1'b0; exp_sat = 1'b0; exp_pw = '0; exp_clk5 = 1'b0;
         return;
      end
      s  = d2;
      d2 = d1;
      d1 = raw_v;
      since_rst++;
      exp_clk5 = ((since_rst - 1) % 5) < 2;
      if (ready) begin
         if (s) begin
            run_len++;
            if (run_len > MaxW) begin
               exp_pw = 8'(MaxW); exp_sat = 1'b1; exp_valid = 1'b1;
               ready = 1'b0; low_len = 0; run_len = 0;
            end
         end else begin
            if (run_len >= MinW) begin
               exp_pw = 8'(run_len); exp_sat = 1'b0; exp_valid = 1'b1;
               ready = 1'b0; low_len = 0;
            end else if (run_len > 0) begin
               exp_glitch = 1'b1;
            end
            run_len = 0;
         end
      end else begin
         if (s) low_len = 0;
         else low_len++;
         if (low_len == GapN) ready = 1'b1;
      end
      exp_clean = ready && (run_len >= MinW);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic tick(input logic raw_v, input logic rst_v);
      @(negedge clk);
      bus.raw_pulse = raw_v;
      rst           = rst_v;
      @(posedge clk);
      #1;
      cyc++;
      model_step(raw_v, rst_v);
      check_eq("clean_pulse", 32'(bus.clean_pulse), 32'(exp_clean));
      check_eq("clk_by_5",    32'(bus.clk_by_5),    32'(exp_clk5));
      check_eq("width_valid", 32'(bus.width_valid), 32'(exp_valid));
      check_eq("glitch",      32'(bus.glitch),      32'(exp_glitch));
      check_eq("pulse_width", 32'(bus.pulse_width), 32'(exp_pw));
      check_eq("width_sat",   32'(bus.width_sat),   32'(exp_sat));
      if (bus.clean_pulse) clean_seen++;
   endtask

   task automatic pulse(input int hi, input int lo);
      for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; cyc = 0; clean_seen = 0;
      bus.raw_pulse = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);

      // Divider free run straight out of reset
      for (int i = 0; i < 50; i++) tick(1'b0, 1'b0);

      clean_seen = 0;
      pulse(10, 10);
      check_eq("clean_len_10", 32'(clean_seen), 32'd8);
      check_eq("width_10", 32'(bus.pulse_width), 32'd10);

      clean_seen = 0;
      pulse(2, 10);
      check_eq("clean_len_glitch", 32'(clean_seen), 32'd0);
      check_eq("width_after_glitch", 32'(bus.pulse_width), 32'd10);

      clean_seen = 0;
      pulse(300, 10);
      check_eq("clean_len_sat", 32'(clean_seen), 32'd253);
      check_eq("width_sat_val", 32'(bus.pulse_width), 32'd255);
      check_eq("sat_flag", 32'(bus.width_sat), 32'd1);

      pulse(10, 2);
      pulse(10, 6);
      pulse(5, 10);
      check_eq("width_after_gap", 32'(bus.pulse_width), 32'd5);

      // Reset during the 5th high cycle of a 20-cycle pulse
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check_eq("clean_on_rst", 32'(bus.clean_pulse), 32'd0);
      clean_seen = 0;
      pulse(15, 10);
      check_eq("width_after_rst", 32'(bus.pulse_width), 32'd15);

      for (int k = 0; k < 150; k++) begin
         int hi, lo;
         hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 270))
                                            : int'($urandom_range(1, 14));
         lo = int'($urandom_range(1, 7));
         if ($urandom_range(0, 29) == 0) begin
            for (int i = 0; i < hi / 2; i++) tick(1'b1, 1'b0);
            tick(1'b1, 1'b1);
            pulse(hi - hi / 2, lo);
         end else begin
            pulse(hi, lo);
         end
      end
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
